// File: rtl/nn_sequencer.sv
// rtl/nn_sequencer.sv - control FSM for the 4-neuron perceptron array
// Streams parameters and inputs into the banks, runs the feedback passes, then presents the results.
module nn_sequencer #(
  parameter int DATA_W     = 8,
  parameter int N_NEURONS  = 4,
  parameter int N_PARAMS   = 6,
  parameter int N_LAYERS   = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              skip_params,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] data_out,
  output logic              param_we,
  output logic [4:0]        param_addr,
  output logic              input_we,
  output logic [1:0]        input_addr,
  output logic              capture_en,
  output logic [1:0]        stage,
  output logic [1:0]        out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              params_valid
);

  localparam int LW = $clog2(N_LAYERS + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [4:0]    P_LAST  = 5'(N_NEURONS * N_PARAMS - 1);
  localparam logic [1:0]    I_LAST  = 2'(N_NEURONS - 1);
  localparam logic [LW-1:0] L_FINAL = LW'(N_LAYERS);
  localparam logic [SW-1:0] S_DONE  = SW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_P,
    S_LOAD_I,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  state_t        state;
  logic [4:0]    pcnt;
  logic [1:0]    icnt;
  logic [SW-1:0] scnt;
  logic [LW-1:0] lcnt;

  logic in_acc;
  logic out_acc;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  // out_sel doubles as the output counter: it is exactly the index being presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      pcnt         <= '0;
      icnt         <= '0;
      scnt         <= '0;
      lcnt         <= '0;
      in_ready     <= 1'b0;
      data_out     <= '0;
      param_we     <= 1'b0;
      param_addr   <= '0;
      input_we     <= 1'b0;
      input_addr   <= '0;
      capture_en   <= 1'b0;
      stage        <= 2'b00;
      out_sel      <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      params_valid <= 1'b0;
    end else begin
      param_we   <= 1'b0;
      input_we   <= 1'b0;
      capture_en <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        pcnt      <= '0;
        icnt      <= '0;
        scnt      <= '0;
        lcnt      <= '0;
        out_sel   <= '0;
        in_ready  <= 1'b0;
        out_valid <= 1'b0;
        stage     <= 2'b00;
        busy      <= 1'b0;
        if (state == S_LOAD_P) params_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              busy     <= 1'b1;
              in_ready <= 1'b1;
              if (skip_params && params_valid) begin
                state <= S_LOAD_I;
                stage <= 2'b01;
              end else begin
                state        <= S_LOAD_P;
                stage        <= 2'b00;
                params_valid <= 1'b0;
              end
            end
          end
          S_LOAD_P: begin
            if (in_acc) begin
              data_out   <= in_data;
              param_we   <= 1'b1;
              param_addr <= pcnt;
              if (pcnt == P_LAST) begin
                pcnt         <= '0;
                params_valid <= 1'b1;
                state        <= S_LOAD_I;
                stage        <= 2'b01;
              end else begin
                pcnt <= pcnt + 5'd1;
              end
            end
          end
          S_LOAD_I: begin
            if (in_acc) begin
              data_out   <= in_data;
              input_we   <= 1'b1;
              input_addr <= icnt;
              if (icnt == I_LAST) begin
                icnt     <= '0;
                scnt     <= '0;
                lcnt     <= '0;
                in_ready <= 1'b0;
                state    <= S_COMPUTE;
                stage    <= 2'b10;
              end else begin
                icnt <= icnt + 2'd1;
              end
            end
          end
          S_COMPUTE: begin
            // Settle counting starts in the cycle of the last input write and restarts on each capture.
            if (capture_en && (lcnt == L_FINAL)) begin
              lcnt      <= '0;
              scnt      <= '0;
              out_sel   <= '0;
              out_valid <= 1'b1;
              state     <= S_OUTPUT;
              stage     <= 2'b11;
            end else if (scnt == S_DONE) begin
              capture_en <= 1'b1;
              scnt       <= '0;
              lcnt       <= lcnt + LW'(1);
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          S_OUTPUT: begin
            if (out_acc) begin
              if (out_sel == I_LAST) begin
                out_sel   <= '0;
                out_valid <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                stage     <= 2'b00;
                state     <= S_IDLE;
              end else begin
                out_sel <= out_sel + 2'd1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_sequencer.sv
// tb/tb_nn_sequencer.sv - scoreboard bench for nn_sequencer
// Stimulus queues expected strobes; a negedge monitor pops and compares them as the DUT emits them.
module tb_nn_sequencer;

  localparam int K_PW = 0, K_IW = 1, K_CAP = 2, K_OUT = 3, K_DONE = 4;

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn, start, skip_params, abort, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, param_we, input_we, capture_en, out_valid, busy, done, params_valid;
  logic [7:0] data_out;
  logic [4:0] param_addr;
  logic [1:0] input_addr, stage, out_sel;

  logic       b_start, b_in_valid;
  logic [7:0] b_in_data;
  logic       b_in_ready, b_param_we, b_input_we, b_capture_en, b_out_valid, b_busy, b_done, b_params_valid;
  logic [7:0] b_data_out;
  logic [4:0] b_param_addr;
  logic [1:0] b_input_addr, b_stage, b_out_sel;

  always #5 clk = ~clk;

  nn_sequencer u_dut (
    .clk(clk), .rstn(rstn), .start(start), .skip_params(skip_params), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .data_out(data_out),
    .param_we(param_we), .param_addr(param_addr), .input_we(input_we), .input_addr(input_addr),
    .capture_en(capture_en), .stage(stage), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .params_valid(params_valid)
  );

  nn_sequencer #(.N_LAYERS(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .start(b_start), .skip_params(1'b0), .abort(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .data_out(b_data_out),
    .param_we(b_param_we), .param_addr(b_param_addr), .input_we(b_input_we), .input_addr(b_input_addr),
    .capture_en(b_capture_en), .stage(b_stage), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(1'b1), .busy(b_busy), .done(b_done), .params_valid(b_params_valid)
  );

  ev_t exp_q[$];
  int  n_vec = 0, n_err = 0;
  int  cyc = 0, last_iw = 0;
  int  b_caps = 0, b_last_iw = 0, b_last_cap = 0, b_first_out = 0, b_dones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
  endtask

  task automatic pop_cmp(input int kind, input int addr, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d addr %0d, expected none (t=%0t)", kind, addr, $time);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_addr", addr, e.addr);
      chk("ev_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (param_we || input_we || capture_en || done)
        chk("strobe_excl", 32'(param_we) + 32'(input_we) + 32'(capture_en) + 32'(done), 1);
      if (param_we) pop_cmp(K_PW, int'(param_addr), int'(data_out));
      if (input_we) begin
        pop_cmp(K_IW, int'(input_addr), int'(data_out));
        last_iw = cyc;
      end
      if (capture_en) begin
        pop_cmp(K_CAP, 0, 0);
        chk("settle_gap", cyc - last_iw, 3);
      end
      if (out_valid && exp_q.size() > 0 && exp_q[0].kind == K_OUT)
        chk("out_sel", out_sel, exp_q[0].addr);
      if (out_valid && out_ready) pop_cmp(K_OUT, int'(out_sel), 0);
      if (done) pop_cmp(K_DONE, 0, 0);

      if (b_input_we) b_last_iw = cyc;
      if (b_capture_en) begin
        b_caps++;
        chk("b_cap_gap", cyc - ((b_caps == 1) ? b_last_iw : b_last_cap), 3);
        b_last_cap = cyc;
      end
      if (b_out_valid && b_first_out == 0) b_first_out = cyc;
      if (b_done) b_dones++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_start(input logic skip);
    start = 1'b1;
    skip_params = skip;
    @(posedge clk);
    #1;
    start = 1'b0;
    skip_params = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        timeout("in_ready");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_param(input int p, input logic [7:0] b);
    exp_q.push_back('{K_PW, p, int'(b)});
    send_byte(b);
  endtask

  task automatic send_input(input int i, input logic [7:0] b);
    exp_q.push_back('{K_IW, i, int'(b)});
    send_byte(b);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 50) begin
        timeout("out_valid");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic take_out(input int hold);
    wait_out_valid();
    idle(hold);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic full_run(input logic skip, input int gap, input int hold,
                          input logic [7:0] pbase, input logic [7:0] ibase);
    drive_start(skip);
    if (!skip) begin
      for (int p = 0; p < 24; p++) begin
        send_param(p, pbase + 8'(p));
        if (gap > 0) idle(gap);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_input(i, ibase + 8'(16 * i));
      if (gap > 0) idle(gap);
    end
    exp_q.push_back('{K_CAP, 0, 0});
    for (int o = 0; o < 4; o++) exp_q.push_back('{K_OUT, o, 0});
    exp_q.push_back('{K_DONE, 0, 0});
    for (int o = 0; o < 4; o++) take_out((o == 0) ? hold : 0);
    idle(3);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_abort(input logic with_valid);
    in_valid = with_valid;
    in_data = 8'hAA;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] b);
    int n;
    n = 0;
    b_in_data = b;
    b_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (b_in_ready) break;
      n++;
      if (n > 50) begin
        timeout("b_in_ready");
        break;
      end
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  function automatic logic [31:0] out_vec();
    return {5'd0, in_ready, data_out, param_we, param_addr, input_we, input_addr, capture_en,
            stage, out_sel, out_valid, busy, done, params_valid};
  endfunction

  initial begin
    rstn = 1'b0; start = 1'b0; skip_params = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), 0);
    rstn = 1'b1;
    idle(1);

    // Reset in the middle of a parameter load
    drive_start(1'b0);
    for (int p = 0; p < 10; p++) send_param(p, 8'hC0 + 8'(p));
    idle(1);
    chk("midload_stage", {busy, stage}, 3'b100);
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), 0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    chk("reset_queue", exp_q.size(), 0);

    // Full back-to-back run
    full_run(1'b0, 0, 0, 8'h01, 8'h10);
    chk("pv_after_run", params_valid, 1);

    // Skip parameters, then abort while presenting outputs
    drive_start(1'b1);
    chk("skip_stage", stage, 2'b01);
    for (int i = 0; i < 4; i++) send_input(i, 8'h05 + 8'(16 * i));
    exp_q.push_back('{K_CAP, 0, 0});
    wait_out_valid();
    chk("output_stage", stage, 2'b11);
    pulse_abort(1'b0);
    chk("abort_out_state", {busy, out_valid, in_ready}, 0);
    chk("abort_out_pv", params_valid, 1);
    idle(3);
    chk("abort_out_queue", exp_q.size(), 0);

    // Stalled input and output handshakes
    full_run(1'b0, 1, 5, 8'h40, 8'h11);

    // Abort at pcnt=10 with a byte offered in the same cycle
    drive_start(1'b0);
    for (int p = 0; p < 10; p++) send_param(p, 8'h60 + 8'(p));
    idle(1);
    pulse_abort(1'b1);
    chk("abort_p_state", {busy, in_ready, stage}, 0);
    chk("abort_p_pv", params_valid, 0);
    idle(3);
    chk("abort_p_queue", exp_q.size(), 0);

    // skip_params without a valid parameter set still loads parameters
    drive_start(1'b1);
    chk("skip_nopv_state", {busy, in_ready, stage}, 4'b1100);
    send_param(0, 8'h5A);
    idle(1);
    pulse_abort(1'b0);
    idle(2);
    chk("skip_nopv_queue", exp_q.size(), 0);

    // Three feedback passes on the second instance
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int p = 0; p < 28; p++) b_send(8'(p + 3));
    begin
      int n;
      n = 0;
      while (b_dones == 0 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (b_dones == 0) timeout("b_done");
    end
    idle(2);
    chk("b_capture_count", b_caps, 3);
    chk("b_output_after_last_cap", b_first_out - b_last_cap, 1);
    chk("b_done_count", b_dones, 1);
    chk("b_pv", b_params_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
